uart_rx_oversampled: RTL and testbench
======================================

Name: uart_rx_oversampled

Overview:
UART receive stage that sits directly downstream of the baud-rate timer and consumes its one-cycle `done` tick as a 16x oversampling strobe. It does three things:
- Synchronises the asynchronous serial line.
- Detects and qualifies the start bit at mid-bit.
- Shifts in DBIT data bits LSB-first, checks the stop bit, then presents the byte with a one-cycle completion strobe.

Parameters:
DBIT, 8, number of data bits per frame (5..8)
SB_TICK, 16, oversampling ticks spent in the stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2)
PARITY_ODD, 0, parity sense when RX_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
s_tick  input  1  16x baud strobe from the baud-rate timer `done` output; one clk wide
rx  input  1  asynchronous serial line, idle high
rx_dout  output  DBIT  last received data word, LSB = first bit on the line
rx_done_tick  output  1  one-clk pulse when rx_dout is updated
busy  output  1  high whenever the state machine is not IDLE
frame_err  output  1  stop bit sampled low on the last completed frame
parity_err  output  1  parity mismatch on the last completed frame (see Optional Feature)

Behaviour:
- Reset is asynchronous, active-high. While asserted:
  - state = IDLE.
  - Sync flops = 1.
  - Tick counter s = 0, bit counter n = 0, shift register b = 0.
  - rx_dout = 0, rx_done_tick = 0, busy = 0, frame_err = 0, parity_err = 0.
- Reset asserted mid-frame aborts the frame. No rx_done_tick is produced, and the next frame is received from a clean IDLE.
- Synchroniser: rx passes through 2 flops to give rx_s, which is the only value the FSM reads. This adds 2 clk of latency before a falling edge is seen.
- The counters are sized as follows:
  - s is 5 bits; it counts s_tick pulses only and is cleared on every state change.
  - n is ceil(log2(DBIT)) bits.
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE:
  - s_tick is ignored.
  - If rx_s == 0 → START with s = 0.
- START, on each s_tick:
  - If s == 7 and rx_s == 0 → DATA with s = 0, n = 0. This is the mid-start-bit sample.
  - If s == 7 and rx_s == 1 → IDLE. This is glitch rejection; no flags change.
  - Otherwise s++.
- DATA, on each s_tick:
  - If s == 15: s = 0 and b = {rx_s, b[DBIT-1:1]}.
    - If n == DBIT-1 → PARITY (macro) or STOP.
    - Otherwise n++.
  - Otherwise s++.
- PARITY, on each s_tick:
  - If s == 15: capture rx_s as the parity bit, then → STOP with s = 0.
  - Otherwise s++.
- STOP, on each s_tick:
  - If s == SB_TICK-1, all of the following happen in the same clk edge, then → IDLE:
    - rx_dout ← b.
    - frame_err ← ~rx_s.
    - parity_err ← mismatch (macro) or 0.
    - rx_done_tick = 1 for exactly that one clk.
  - Otherwise s++.
- A frame with a bad stop bit still completes: rx_done_tick pulses, rx_dout is updated and frame_err = 1.
- rx_dout, frame_err and parity_err hold their values until the next completed frame.
- Back-to-back frames: IDLE is re-entered on the clk after the stop sample. A start edge already present on rx_s is taken immediately, with no idle gap required.
- Line stuck low after a frame: the FSM re-enters START and receives a 0x00 frame with frame_err = 1. It does not lock up.
- s_tick asserted on consecutive clks is legal. Each high clk counts as one tick.
- busy = (state != IDLE). It is combinational from the state register.

Optional Feature:
Macro RX_PARITY_EN.
- Defined:
  - The PARITY state is instantiated and a parity bit is expected after the data bits.
  - parity_err = (^b) ^ parity_bit ^ PARITY_ODD, registered at the stop sample.
  - Frame length is 1 + DBIT + 1 + stop.
- Undefined:
  - No PARITY state; DATA goes straight to STOP.
  - parity_err is tied to constant 0.
  - The port list is identical in both builds.

Test Plan:
All cases use the baud-rate timer with FINAL_VALUE = 3 (s_tick every 4 clk), DBIT = 8, SB_TICK = 16, so one bit = 64 clk.
1. Send 0x55 as 8N1, no macro → rx_done_tick pulses exactly once, about 9.5 bit times after the start edge. rx_dout = 0x55, frame_err = 0, busy low afterward.
2. Send 0xA3 immediately followed by 0x0F, no idle gap → two rx_done_tick pulses 640 clk apart, with rx_dout = 0xA3 then 0x0F.
3. Drive rx low for 16 clk (a 4-tick glitch), then high → FSM returns to IDLE from START. No rx_done_tick; rx_dout and flags are unchanged.
4. Send 0xC3 with the stop bit forced low → rx_done_tick pulses, rx_dout = 0xC3, frame_err = 1. The next good frame 0x12 clears frame_err to 0.
5. Assert reset during data bit 4 of a frame, release, then send 0x7E → no pulse for the aborted frame; all outputs are 0 during reset; 0x7E is received correctly.
6. With RX_PARITY_EN and PARITY_ODD = 0, send 0x07 with parity bit 1 → parity_err = 0. Send it again with parity bit 0 → parity_err = 1, and rx_dout = 0x07 both times.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// UART receiver clocked by a 16x oversampling tick: 2-flop synchroniser, mid-bit start
// qualification, LSB-first shift-in and stop check. Optional parity bit: define RX_PARITY_EN.
module uart_rx_oversampled #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            busy,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int unsigned   SW     = 5;
  localparam int unsigned   NW     = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic          P_SENSE = 1'(PARITY_ODD);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t          r_state, w_state;
  logic [1:0]      r_sync;
  logic [SW-1:0]   r_s, w_s;
  logic [NW-1:0]   r_n, w_n;
  logic [DBIT-1:0] r_b, w_b;
  logic [DBIT-1:0] r_dout, w_dout;
  logic            r_done, w_done;
  logic            r_ferr, w_ferr;
  logic            w_rx_s;
`ifdef RX_PARITY_EN
  logic            r_par, w_par;
  logic            r_perr, w_perr;
`endif

  assign w_rx_s = r_sync[1];

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_sync  <= 2'b11;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef RX_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_sync  <= {r_sync[0], rx};
      r_s     <= w_s;
      r_n     <= w_n;
      r_b     <= w_b;
      r_dout  <= w_dout;
      r_done  <= w_done;
      r_ferr  <= w_ferr;
`ifdef RX_PARITY_EN
      r_par   <= w_par;
      r_perr  <= w_perr;
`endif
    end
  end

  // Next-state and datapath update; s only advances on s_tick outside IDLE
  always_comb begin
    w_state = r_state;
    w_s     = r_s;
    w_n     = r_n;
    w_b     = r_b;
    w_dout  = r_dout;
    w_done  = 1'b0;
    w_ferr  = r_ferr;
`ifdef RX_PARITY_EN
    w_par   = r_par;
    w_perr  = r_perr;
`endif
    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state = START;
          w_s     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (r_s == S_MID) begin
            w_s = '0;
            if (!w_rx_s) begin
              w_state = DATA;
              w_n     = '0;
            end else begin
              w_state = IDLE;
            end
          end else begin
            w_s = r_s + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (r_s == S_BIT) begin
            w_s = '0;
            w_b = {w_rx_s, r_b[DBIT-1:1]};
            if (r_n == N_LAST) begin
`ifdef RX_PARITY_EN
              w_state = PARITY;
`else
              w_state = STOP;
`endif
            end else begin
              w_n = r_n + NW'(1);
            end
          end else begin
            w_s = r_s + SW'(1);
          end
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (r_s == S_BIT) begin
            w_par   = w_rx_s;
            w_state = STOP;
            w_s     = '0;
          end else begin
            w_s = r_s + SW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (r_s == S_STOP) begin
            w_state = IDLE;
            w_s     = '0;
            w_dout  = r_b;
            w_ferr  = ~w_rx_s;
            w_done  = 1'b1;
`ifdef RX_PARITY_EN
            w_perr  = (^r_b) ^ r_par ^ P_SENSE;
`endif
          end else begin
            w_s = r_s + SW'(1);
          end
        end
      end
      default: begin
        w_state = IDLE;
        w_s     = '0;
      end
    endcase
  end

  assign rx_dout      = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;
  assign busy         = (r_state != IDLE);
`ifdef RX_PARITY_EN
  assign parity_err   = r_perr;
`else
  // No parity bit on the line: flag is held low and the sense parameter has no effect
  assign parity_err   = 1'b0 & P_SENSE;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: directed frame table, multi-cycle corner sequences and
// random frames against a frame-level reference model. Parity cases need RX_PARITY_EN.
module tb_uart_rx_oversampled;

  localparam int unsigned DBIT    = 8;
  localparam int unsigned SB_TICK = 16;
  localparam int unsigned PODD    = 0;
`ifdef RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       rx;
  logic [7:0] rx_dout;
  logic       rx_done_tick;
  logic       busy;
  logic       frame_err;
  logic       parity_err;

  uart_rx_oversampled #(.DBIT(DBIT), .SB_TICK(SB_TICK), .PARITY_ODD(PODD)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .rx_dout      (rx_dout),
    .rx_done_tick (rx_done_tick),
    .busy         (busy),
    .frame_err    (frame_err),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    int         t;
  } rec_t;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       stop_ok;
    logic [7:0] exp_d;
    logic       exp_fe;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   tcnt  = 0;
  bit   tick_rand = 1'b0;
  rec_t got[$];
  exp_t expq[$];
  vec_t tv[7];

  always @(posedge clk) cyc <= cyc + 1;

  // Completed-frame monitor
  always @(negedge clk) begin
    if (rx_done_tick) got.push_back('{rx_dout, frame_err, parity_err, cyc});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clk; s_tick either follows a divide-by-4 timer or is random
  task automatic step();
    @(negedge clk);
    if (tick_rand) begin
      s_tick = 1'($urandom_range(0, 1));
    end else begin
      tcnt   = (tcnt + 1) % 4;
      s_tick = (tcnt == 3);
    end
  endtask

  // Drive the line at v for nt ticks
  task automatic hold(input logic v, input int nt);
    int k     = 0;
    int guard = 0;
    rx = v;
    while (k < nt) begin
      step();
      guard++;
      if (s_tick) k++;
      if (guard > nt * 64 + 64) begin
        check("tick_timeout", 32'(k), 32'(nt));
        break;
      end
    end
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ 1'(PODD);
  endfunction

  // A bad stop is held low through its sample point, then released for the last quarter
  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic pbit);
    hold(1'b0, 16);
    for (int i = 0; i < 8; i++) hold(d[i], 16);
    if (PB != 0) hold(pbit, 16);
    if (stop_ok) begin
      hold(1'b1, 16);
    end else begin
      hold(1'b0, 12);
      hold(1'b1, 4);
    end
  endtask

  initial begin
    int          t0;
    logic [7:0]  d;
    logic        ok;
    logic        pb;
    int          n;

    tv[0] = '{8'h55, 1'b1, 8'h55, 1'b0};
    tv[1] = '{8'hA3, 1'b1, 8'hA3, 1'b0};
    tv[2] = '{8'hC3, 1'b0, 8'hC3, 1'b1};
    tv[3] = '{8'h12, 1'b1, 8'h12, 1'b0};
    tv[4] = '{8'h00, 1'b1, 8'h00, 1'b0};
    tv[5] = '{8'hFF, 1'b0, 8'hFF, 1'b1};
    tv[6] = '{8'h81, 1'b1, 8'h81, 1'b0};

    reset  = 1'b1;
    rx     = 1'b1;
    s_tick = 1'b0;
    repeat (4) step();
    check("rst_dout",  32'(rx_dout), 32'h0);
    check("rst_done",  32'(rx_done_tick), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_ferr",  32'(frame_err), 32'h0);
    check("rst_perr",  32'(parity_err), 32'h0);
    reset = 1'b0;
    hold(1'b1, 8);

    // Single frame: latency from the falling start edge to the done pulse
    got.delete();
    t0 = cyc;
    send_frame(8'h55, 1'b1, good_par(8'h55));
    hold(1'b1, 16);
    check("t1_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) begin
      check("t1_latency", 32'(got[0].t - t0), 32'(609 + 64 * PB));
      check("t1_dout", 32'(got[0].d), 32'h55);
    end
    check("t1_busy", 32'(busy), 32'h0);

    // Directed frame table
    for (int i = 0; i < 7; i++) begin
      got.delete();
      send_frame(tv[i].d, tv[i].stop_ok, good_par(tv[i].d));
      hold(1'b1, 16);
      check($sformatf("tv%0d_count", i), 32'(got.size()), 32'd1);
      if (got.size() > 0) begin
        check($sformatf("tv%0d_dout", i), 32'(got[0].d), 32'(tv[i].exp_d));
        check($sformatf("tv%0d_ferr", i), 32'(got[0].fe), 32'(tv[i].exp_fe));
        check($sformatf("tv%0d_perr", i), 32'(got[0].pe), 32'h0);
      end
      check($sformatf("tv%0d_busy", i), 32'(busy), 32'h0);
    end

    // Back-to-back frames with no idle gap
    got.delete();
    send_frame(8'hA3, 1'b1, good_par(8'hA3));
    send_frame(8'h0F, 1'b1, good_par(8'h0F));
    hold(1'b1, 16);
    check("b2b_count", 32'(got.size()), 32'd2);
    if (got.size() > 1) begin
      check("b2b_first",  32'(got[0].d), 32'hA3);
      check("b2b_second", 32'(got[1].d), 32'h0F);
      check("b2b_gap",    32'(got[1].t - got[0].t), 32'(640 + 64 * PB));
    end

    // 16-clk glitch: START entered then rejected at mid-bit
    got.delete();
    rx = 1'b0;
    repeat (16) step();
    check("glitch_busy_hi", 32'(busy), 32'h1);
    hold(1'b1, 32);
    check("glitch_count", 32'(got.size()), 32'd0);
    check("glitch_dout",  32'(rx_dout), 32'h0F);
    check("glitch_ferr",  32'(frame_err), 32'h0);
    check("glitch_busy",  32'(busy), 32'h0);

    // Reset in the middle of data bit 4 aborts the frame
    got.delete();
    d = 8'hA5;
    hold(1'b0, 16);
    for (int i = 0; i < 4; i++) hold(d[i], 16);
    hold(d[4], 8);
    check("abort_busy_pre", 32'(busy), 32'h1);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) step();
    check("abort_dout", 32'(rx_dout), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(rx_done_tick), 32'h0);
    check("abort_ferr", 32'(frame_err), 32'h0);
    reset = 1'b0;
    hold(1'b1, 16);
    check("abort_count", 32'(got.size()), 32'd0);
    send_frame(8'h7E, 1'b1, good_par(8'h7E));
    hold(1'b1, 16);
    check("post_abort_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) begin
      check("post_abort_dout", 32'(got[0].d), 32'h7E);
      check("post_abort_ferr", 32'(got[0].fe), 32'h0);
    end

    // Line stuck low for one frame plus part of the next start bit
    got.delete();
    hold(1'b0, 156 + 16 * PB);
    hold(1'b1, 64);
    check("stuck_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) begin
      check("stuck_dout", 32'(got[0].d), 32'h00);
      check("stuck_ferr", 32'(got[0].fe), 32'h1);
    end
    check("stuck_busy", 32'(busy), 32'h0);

    // Random frames, random tick spacing, checked against the frame-level model
    tick_rand = 1'b1;
    got.delete();
    expq.delete();
    for (int i = 0; i < 24; i++) begin
      d  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      pb = 1'($urandom_range(0, 1));
      send_frame(d, ok, pb);
      expq.push_back('{d, ~ok, (PB != 0) ? ((^d) ^ pb ^ 1'(PODD)) : 1'b0});
      if (ok) hold(1'b1, $urandom_range(0, 3));
      else    hold(1'b1, 16 + $urandom_range(0, 3));
    end
    hold(1'b1, 32);
    check("rand_count", 32'(got.size()), 32'(expq.size()));
    n = (got.size() < expq.size()) ? got.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("rand%0d_dout", i), 32'(got[i].d),  32'(expq[i].d));
      check($sformatf("rand%0d_ferr", i), 32'(got[i].fe), 32'(expq[i].fe));
      check($sformatf("rand%0d_perr", i), 32'(got[i].pe), 32'(expq[i].pe));
    end
    tick_rand = 1'b0;
    check("rand_busy", 32'(busy), 32'h0);

`ifdef RX_PARITY_EN
    // Even parity: 0x07 has odd weight so the correct parity bit is 1
    got.delete();
    send_frame(8'h07, 1'b1, 1'b1);
    hold(1'b1, 16);
    send_frame(8'h07, 1'b1, 1'b0);
    hold(1'b1, 16);
    check("par_count", 32'(got.size()), 32'd2);
    if (got.size() > 1) begin
      check("par_good_perr", 32'(got[0].pe), 32'h0);
      check("par_good_dout", 32'(got[0].d),  32'h07);
      check("par_bad_perr",  32'(got[1].pe), 32'h1);
      check("par_bad_dout",  32'(got[1].d),  32'h07);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
